instr_register_scheduler: RTL
=============================

# instr_register_scheduler

Front-end controller for the instruction register. It arbitrates two instruction requesters onto the register's single load port using round-robin, and auto-increments `write_pointer` with wrap. It also drives `read_pointer` in FIFO order for a single consumer, and reports occupancy. It sits between the stimulus/producer side and `instr_register`, replacing hand-driven pointer control.

## Interface
Types `opcode_t`, `operand_t` and `address_t` come from `instr_register_pkg`.

Parameters:
- `DEPTH`, 32: number of register locations.
- `ADDR_W`, 5: pointer width; `DEPTH == 2**ADDR_W`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of queue state.
- `req0_valid` in 1: requester 0 has an instruction.
- `req0_ready` out 1: requester 0 granted this cycle.
- `req0_opcode`, `req0_operand_a`, `req0_operand_b` in opcode_t/operand_t/operand_t: requester 0 payload.
- `req1_valid`, `req1_ready`, `req1_opcode`, `req1_operand_a`, `req1_operand_b`: same for requester 1.
- `pop_valid` in 1: consumer requests the oldest entry.
- `pop_ready` out 1: an entry is available.
- `rsp_valid` out 1: `instruction_word` at the register output is the popped entry.
- `load_en` out 1: to instr_register.
- `write_pointer` out address_t: to instr_register.
- `opcode`, `operand_a`, `operand_b` out opcode_t/operand_t/operand_t: to instr_register.
- `read_pointer` out address_t: to instr_register.
- `count` out ADDR_W+1: number of committed entries, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.

## Operation
Write arbitration:
- `accept = !full && !flush && !reset`.
- Only one requester valid: it is granted if `accept`.
- Both requesters valid: the one not in `last_grant` wins.
- `reqN_ready` is combinational: 1 only for the winner, and only when `reqN_valid` is high.
- A transfer happens when `reqN_valid && reqN_ready` at a clock edge.
- On a transfer, `last_grant` is set to N. The loser stays pending; requesters must hold valid and payload stable until ready.
- `full` blocks writes even when a pop occurs in the same cycle. There is no bypass.

Write commit:
- On a transfer, register `load_en=1`, `write_pointer=wp`, and the winner's payload.
- Then `wp <= wp+1`, wrapping from DEPTH-1 to 0, and `count` increments.
- With no transfer, `load_en` returns to 0. The payload outputs hold their last values.

Read:
- `pop_ready = !empty && !flush`.
- On a pop transfer: `read_pointer <= rp`, `rp <= rp+1` with wrap, `count` decrements, and `rsp_valid` is 1 for the next cycle only.
- Entries leave in exactly the order they were granted.

Count rules:
- Write and pop in the same cycle: `count` unchanged, both pointers advance.
- `count` never exceeds DEPTH and never underflows.

Flush:
- Takes priority over both requests.
- Both readies are forced to 0 in the flush cycle.
- Next cycle: `wp=rp=0`, `count=0`, `load_en=0`, `rsp_valid=0`.
- `last_grant` and payload outputs are unchanged.

Status: `full` and `empty` are decoded from the registered `count`.

## Timing
Reset values (one edge with `reset` high):
- `load_en=0`, `write_pointer=0`, `read_pointer=0`.
- `opcode=ZERO`, `operand_a=0`, `operand_b=0`.
- `rsp_valid=0`, `count=0`, `empty=1`, `full=0`.
- Internal: `wp=rp=0`, `last_grant=1`, so req0 wins the first contention.
- Reset asserted mid-operation discards all queued entries. Register contents are not cleared; they are simply unreachable.

Write latency:
- Handshake at edge k.
- `load_en` and payload are valid during cycle k..k+1.
- instr_register captures the entry at edge k+1.

Read latency:
- An entry granted at edge k gives `count>0` after k, so the earliest pop is at edge k+1.
- `read_pointer` updates at edge k+1, which is the same edge the register captures the data.
- `rsp_valid` and the data are therefore valid together during cycle k+1..k+2.

Throughput: one write and one read per cycle, sustained.

## Test plan
- **Reset:** assert `reset` 2 cycles with `req0_valid=1` → `req0_ready=0`, all outputs at reset values, `empty=1`.
- **Round-robin:** both valid for 4 cycles from reset → grants req0, req1, req0, req1; `write_pointer` 0,1,2,3 with `load_en=1`; `count=4`.
- **Full and wrap:** 32 req0 writes → `full=1`, `count=32`, `req0_ready=0`. One pop → next write is accepted with `write_pointer=0`.
- **Concurrent write and pop:** write and pop in the same cycle at `count=5` → `count` stays 5, both pointers advance by 1.
- **Data path:** req1 sends ADD a=3 b=4, then pop → `rsp_valid=1`, `read_pointer=0`, `instruction_word.opc=ADD`, `result=7` in the same cycle.
- **Flush:** flush at `count=10` with both requesters valid → both readies 0 that cycle; next cycle `count=0`, `empty=1`, `load_en=0`, `wp=rp=0`.

Source files
------------

// File: rtl/instr_register_scheduler.sv
// Round-robin write arbiter and FIFO pointer controller for instr_register.
// Two requesters share one load port. A single consumer pops entries in grant order.
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
endpackage

module instr_register_scheduler
  import instr_register_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  opcode_t           req0_opcode,
  input  operand_t          req0_operand_a,
  input  operand_t          req0_operand_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  opcode_t           req1_opcode,
  input  operand_t          req1_operand_a,
  input  operand_t          req1_operand_b,
  input  logic              pop_valid,
  output logic              pop_ready,
  output logic              rsp_valid,
  output logic              load_en,
  output address_t          write_pointer,
  output opcode_t           opcode,
  output operand_t          operand_a,
  output operand_t          operand_b,
  output address_t          read_pointer,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              last_grant;
  logic              accept;
  logic              wr;
  logic              pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // last_grant names the requester that lost priority; the other wins a tie.
  always_comb begin
    accept     = !full && !flush && !reset;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept) begin
      req0_ready = req0_valid && (!req1_valid || last_grant);
      req1_ready = req1_valid && (!req0_valid || !last_grant);
    end
    wr        = req0_ready || req1_ready;
    pop_ready = !empty && !flush;
    pop       = pop_valid && pop_ready;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      last_grant    <= 1'b1;
      load_en       <= 1'b0;
      write_pointer <= '0;
      read_pointer  <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      rsp_valid     <= 1'b0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      load_en   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      load_en   <= wr;
      rsp_valid <= pop;
      if (wr) begin
        write_pointer <= wp;
        wp            <= wp + 1'b1;
        last_grant    <= req1_ready;
        if (req0_ready) begin
          opcode    <= req0_opcode;
          operand_a <= req0_operand_a;
          operand_b <= req0_operand_b;
        end else begin
          opcode    <= req1_opcode;
          operand_a <= req1_operand_a;
          operand_b <= req1_operand_b;
        end
      end
      if (pop) begin
        read_pointer <= rp;
        rp           <= rp + 1'b1;
      end
      if (wr && !pop) begin
        count <= count + 1'b1;
      end else if (!wr && pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
